arm_multicycle_ctrl: RTL and testbench
======================================

Name: arm_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the multicycle ARM datapath (shared instruction/data memory, IR, single ALU reused for PC increment).
- Replaces the single-cycle main decoder. Takes Op/Funct/Rd from the instruction register plus the external condition-check result, and emits per-state datapath enables.
- The existing ALU decoder stays downstream and consumes ALUOp and Funct.
- Adds a memory-ready handshake and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- Op  in  2  IR[27:26]
- Funct  in  6  IR[25:20]
- Rd  in  4  IR[15:12]
- CondEx  in  1  condition passed, from the condition unit
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALU result register, as memory address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  1  0 = RD1, 1 = PC
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
- ALUOp  out  1  enables the Funct-based ALU decode
- RegWrite  out  1  register-file write enable
- Branch  out  1  branch state indicator
- instr_done  out  1  one-cycle pulse on instruction completion
- illegal  out  1  one-cycle pulse, Op = 11 decoded
- retire_count  out  CNT_W  instructions completed

Behaviour:
Clocking and reset
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- On reset: state = FETCH, retire_count = 0.
- Outputs are combinational from state. While in reset they show FETCH decoding with mem_ready low: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0; all strobes 0.
- Reset mid-instruction aborts it. No write strobe is asserted in the cycle after rst_n deasserts.

State encoding (4 bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10–15 go to FETCH next cycle with all strobes 0.

FETCH
- Outputs: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
- Holds until mem_ready. In the cycle mem_ready=1: IRWrite=1 and NextPC=1, next state = DECODE.

DECODE
- Outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (reads PC+8).
- Next state:
  - Op=01 -> MEMADR
  - Op=00 & Funct[5]=0 -> EXECR
  - Op=00 & Funct[5]=1 -> EXECI
  - Op=10 -> BRANCH
  - Op=11 -> FETCH, with illegal=1 and instr_done=0; counter does not increment.

Memory path
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Funct[0]=1 -> MEMRD, else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Waits for mem_ready, then -> MEMWB.
- MEMWB: ResultSrc=01, RegW=1 -> FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=1. MemW is held every cycle until mem_ready, then -> FETCH.

ALU path
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1 -> ALUWB.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1 -> ALUWB.
- ALUWB: ResultSrc=00, RegW=1 -> FETCH. RegW is forced 0 when Funct[4:3]=10 (TST/TEQ/CMP/CMN).

BRANCH
- Outputs: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1 -> FETCH.

Output gating
- RegWrite = RegW & CondEx.
- MemWrite = MemW & CondEx.
- PCWrite = NextPC | (CondEx & (Branch | (RegW & Rd==15))).
- MEMRD, MEMWR and ALUWB ignore CondEx for sequencing; the failed instruction still walks its states with writes suppressed.

Completion and counter
- instr_done pulses in the last cycle of MEMWB, ALUWB, BRANCH, and of MEMWR when mem_ready=1. It pulses whether CondEx passes or fails.
- retire_count increments on instr_done and wraps modulo 2^CNT_W.

Latency
- ALU instruction: 4 cycles. Load: 5 cycles. Store: 4 cycles. Branch: 3 cycles.
- Each wait cycle on mem_ready adds 1.

Decomposition:
- Shared package arm_mc_pkg holds:
  - state codes
  - ALUSrcB codes (SRCB_RD2, SRCB_IMM, SRCB_FOUR)
  - ResultSrc codes (RES_ALUOUT, RES_DATA, RES_ALU)
  - Op codes (OP_DP, OP_MEM, OP_BR)
- One sub-module, mc_write_gate: the combinational CondEx/Rd==15 gating of RegWrite, MemWrite and PCWrite. It is reusable by the pipelined variant.

Test Plan:
- ADD R1,R2,R3 (Op=00, Funct=001000, Rd=1), mem_ready=1, CondEx=1 -> states 0,1,6,8,0; RegWrite=1 only in ALUWB; PCWrite only in FETCH; retire_count 0→1.
- LDR (Op=01, Funct[0]=1), mem_ready low 2 cycles in FETCH and 3 in MEMRD -> 10 cycles total; IRWrite exactly once; RegWrite in MEMWB with ResultSrc=01.
- STR with CondEx=0 -> MemWrite never asserted, PC advances, instr_done=1, count increments.
- B (Op=10), CondEx=1 -> PCWrite=1 in BRANCH with ResultSrc=10; CondEx=0 -> PCWrite=0 in BRANCH.
- CMP (Funct=110101) -> RegWrite=0 in ALUWB. MOV PC (Rd=15) -> PCWrite=1 in ALUWB.
- Op=11 -> illegal pulse, return to FETCH, no count. rst_n low during MEMWR -> state=FETCH immediately, MemWrite=0, count=0.

Source files
------------

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM control path: FSM states, datapath
// mux select codes and instruction-class opcodes.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // TST/TEQ/CMP/CMN only update flags; they never write a destination register.
  function automatic logic is_flag_only(input logic [5:0] funct);
    return funct[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/mc_write_gate.sv
// Condition gating of the architectural write enables. Shared with the
// pipelined core so both apply CondEx and the R15-write rule identically.
module mc_write_gate (
  input  logic       i_reg_w,
  input  logic       i_mem_w,
  input  logic       i_next_pc,
  input  logic       i_branch,
  input  logic       i_cond_ex,
  input  logic [3:0] i_rd,
  output logic       o_reg_write,
  output logic       o_mem_write,
  output logic       o_pc_write
);

  logic w_pc_dest;

  assign w_pc_dest   = (i_rd == 4'd15);
  assign o_reg_write = i_reg_w & i_cond_ex;
  assign o_mem_write = i_mem_w & i_cond_ex;
  // A taken branch or a register write to R15 redirects the PC.
  assign o_pc_write  = i_next_pc | (i_cond_ex & (i_branch | (i_reg_w & w_pc_dest)));

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Moore control FSM for the multicycle ARM datapath with a memory-ready
// handshake and a retired-instruction counter.
module arm_multicycle_ctrl
  import arm_mc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic             CondEx,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             ALUOp,
  output logic             RegWrite,
  output logic             Branch,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_count
);

  state_t           r_state;
  logic [CNT_W-1:0] r_retire_count;

  logic       w_mem_ready;
  logic       w_reg_w;
  logic       w_mem_w;
  logic       w_next_pc;
  logic       w_branch;
  logic       w_ir_write;
  logic       w_adr_src;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_result_src;
  logic       w_alu_op;
  logic       w_instr_done;
  logic       w_illegal;
  logic       w_unused;

  // Funct[2:1] select ALU operations downstream and carry no sequencing meaning.
  assign w_unused = ^Funct[2:1];

  // Masking the handshake with rst_n keeps every strobe low while reset is held.
  assign w_mem_ready = mem_ready & rst_n;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_MEM:  r_state <= S_MEMADR;
            OP_DP:   r_state <= Funct[5] ? S_EXECI : S_EXECR;
            OP_BR:   r_state <= S_BRANCH;
            default: r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= Funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
        S_EXECR,
        S_EXECI:  r_state <= S_ALUWB;
        S_MEMWB,
        S_ALUWB,
        S_BRANCH: r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    w_reg_w      = 1'b0;
    w_mem_w      = 1'b0;
    w_next_pc    = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_RD2;
    w_result_src = RES_ALUOUT;
    w_alu_op     = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALU;
        w_ir_write   = w_mem_ready;
        w_next_pc    = w_mem_ready;
      end
      S_DECODE: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALU;
        w_illegal    = (Op == 2'b11);
      end
      S_MEMADR: begin
        w_alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_w      = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEMWR: begin
        w_adr_src    = 1'b1;
        w_mem_w      = 1'b1;
        w_instr_done = w_mem_ready;
      end
      S_EXECR: begin
        w_alu_op = 1'b1;
      end
      S_EXECI: begin
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = 1'b1;
      end
      S_ALUWB: begin
        w_reg_w      = ~is_flag_only(Funct);
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_b  = SRCB_IMM;
        w_result_src = RES_ALU;
        w_branch     = 1'b1;
        w_instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_count <= '0;
    end else if (w_instr_done) begin
      r_retire_count <= r_retire_count + CNT_W'(1);
    end
  end

  mc_write_gate u_write_gate (
    .i_reg_w     (w_reg_w),
    .i_mem_w     (w_mem_w),
    .i_next_pc   (w_next_pc),
    .i_branch    (w_branch),
    .i_cond_ex   (CondEx),
    .i_rd        (Rd),
    .o_reg_write (RegWrite),
    .o_mem_write (MemWrite),
    .o_pc_write  (PCWrite)
  );

  assign AdrSrc       = w_adr_src;
  assign IRWrite      = w_ir_write;
  assign ResultSrc    = w_result_src;
  assign ALUSrcA      = w_alu_src_a;
  assign ALUSrcB      = w_alu_src_b;
  assign ALUOp        = w_alu_op;
  assign Branch       = w_branch;
  assign instr_done   = w_instr_done;
  assign illegal      = w_illegal;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed bench for arm_multicycle_ctrl: each driven cycle queues its expected
// outputs and a negedge monitor pops and compares them.
module tb_arm_multicycle_ctrl;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    Op = 2'b00;
  logic [5:0]    Funct = 6'b0;
  logic [3:0]    Rd = 4'd0;
  logic          CondEx = 1'b0;
  logic          mem_ready = 1'b0;
  logic          PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, ALUOp;
  logic          RegWrite, Branch, instr_done, illegal;
  logic [1:0]    ResultSrc, ALUSrcB;
  logic [CW-1:0] retire_count;

  arm_multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Rd(Rd),
    .CondEx(CondEx), .mem_ready(mem_ready), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .RegWrite(RegWrite), .Branch(Branch),
    .instr_done(instr_done), .illegal(illegal), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef enum {L_FETCH, L_DECODE, L_MEMADR, L_MEMRD, L_MEMWB, L_MEMWR,
                L_EXECR, L_EXECI, L_ALUWB, L_BRANCH} lbl_t;

  typedef struct {
    string         name;
    lbl_t          lbl;
    logic [6:0]    strb;   // {PCWrite, IRWrite, MemWrite, RegWrite, Branch, instr_done, illegal}
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [1:0] ci_op;
  logic [5:0] ci_f;
  logic [3:0] ci_rd;
  logic       ci_cx;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // {mask, value} over {AdrSrc, ALUSrcA, ALUSrcB[1:0], ResultSrc[1:0], ALUOp}
  function automatic logic [13:0] mux_ref(input lbl_t l);
    case (l)
      L_FETCH:  return {7'b1111111, 7'b0110100};
      L_DECODE: return {7'b0111110, 7'b0110100};
      L_MEMADR: return {7'b0111001, 7'b0001000};
      L_MEMRD:  return {7'b1000110, 7'b1000000};
      L_MEMWB:  return {7'b0000110, 7'b0000010};
      L_MEMWR:  return {7'b1000110, 7'b1000000};
      L_EXECR:  return {7'b0111001, 7'b0000001};
      L_EXECI:  return {7'b0111001, 7'b0001001};
      L_ALUWB:  return {7'b0000110, 7'b0000000};
      L_BRANCH: return {7'b0111111, 7'b0001100};
      default:  return 14'b0;
    endcase
  endfunction

  task automatic set_ins(input logic [1:0] op, input logic [5:0] f,
                         input logic [3:0] rd, input logic cx);
    ci_op = op; ci_f = f; ci_rd = rd; ci_cx = cx;
  endtask

  task automatic drive(input string nm, input logic rn, input logic mr, input lbl_t l,
                       input logic [6:0] s, input logic [CW-1:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; Op = ci_op; Funct = ci_f; Rd = ci_rd; CondEx = ci_cx; mem_ready = mr;
    e.name = nm; e.lbl = l; e.strb = s; e.cnt = c;
    q.push_back(e);
  endtask

  task automatic row(input string nm, input logic mr, input lbl_t l,
                     input logic [6:0] s, input logic [CW-1:0] c);
    drive(nm, 1'b1, mr, l, s, c);
  endtask

  exp_t       m_e;
  logic [6:0] m_strb;
  logic [6:0] m_mux;
  logic [13:0] m_ref;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e    = q.pop_front();
      m_strb = {PCWrite, IRWrite, MemWrite, RegWrite, Branch, instr_done, illegal};
      m_mux  = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp};
      m_ref  = mux_ref(m_e.lbl);
      check({m_e.name, ".strb"}, {9'b0, m_strb}, {9'b0, m_e.strb});
      check({m_e.name, ".mux"}, {9'b0, m_mux & m_ref[13:7]}, {9'b0, m_ref[6:0] & m_ref[13:7]});
      check({m_e.name, ".cnt"}, 16'(retire_count), 16'(m_e.cnt));
    end
  end

  initial begin
    set_ins(2'b00, 6'b000000, 4'd0, 1'b1);
    drive("reset", 1'b0, 1'b1, L_FETCH, 7'b0000000, 3'd0);

    set_ins(2'b00, 6'b001000, 4'd1, 1'b1);  // ADD R1,R2,R3
    row("add_f",  1'b1, L_FETCH,  7'b1100000, 3'd0);
    row("add_d",  1'b1, L_DECODE, 7'b0000000, 3'd0);
    row("add_x",  1'b1, L_EXECR,  7'b0000000, 3'd0);
    row("add_wb", 1'b1, L_ALUWB,  7'b0001010, 3'd0);

    set_ins(2'b01, 6'b011001, 4'd2, 1'b1);  // LDR with memory stalls
    row("ldr_f0", 1'b0, L_FETCH,  7'b0000000, 3'd1);
    row("ldr_f1", 1'b0, L_FETCH,  7'b0000000, 3'd1);
    row("ldr_f2", 1'b1, L_FETCH,  7'b1100000, 3'd1);
    row("ldr_d",  1'b0, L_DECODE, 7'b0000000, 3'd1);
    row("ldr_ma", 1'b0, L_MEMADR, 7'b0000000, 3'd1);
    for (int i = 0; i < 3; i++)
      row("ldr_rdw", 1'b0, L_MEMRD, 7'b0000000, 3'd1);
    row("ldr_rd", 1'b1, L_MEMRD,  7'b0000000, 3'd1);
    row("ldr_wb", 1'b0, L_MEMWB,  7'b0001010, 3'd1);

    set_ins(2'b01, 6'b011000, 4'd3, 1'b0);  // STR, condition fails
    row("strn_f",  1'b1, L_FETCH,  7'b1100000, 3'd2);
    row("strn_d",  1'b1, L_DECODE, 7'b0000000, 3'd2);
    row("strn_ma", 1'b1, L_MEMADR, 7'b0000000, 3'd2);
    row("strn_w0", 1'b0, L_MEMWR,  7'b0000000, 3'd2);
    row("strn_w1", 1'b1, L_MEMWR,  7'b0000010, 3'd2);

    set_ins(2'b10, 6'b100000, 4'd0, 1'b1);  // B taken
    row("bt_f",  1'b1, L_FETCH,  7'b1100000, 3'd3);
    row("bt_d",  1'b1, L_DECODE, 7'b0000000, 3'd3);
    row("bt_br", 1'b1, L_BRANCH, 7'b1000110, 3'd3);

    set_ins(2'b10, 6'b100000, 4'd0, 1'b0);  // B not taken
    row("bn_f",  1'b1, L_FETCH,  7'b1100000, 3'd4);
    row("bn_d",  1'b1, L_DECODE, 7'b0000000, 3'd4);
    row("bn_br", 1'b1, L_BRANCH, 7'b0000110, 3'd4);

    set_ins(2'b00, 6'b110101, 4'd0, 1'b1);  // CMP
    row("cmp_f",  1'b1, L_FETCH,  7'b1100000, 3'd5);
    row("cmp_d",  1'b1, L_DECODE, 7'b0000000, 3'd5);
    row("cmp_x",  1'b1, L_EXECI,  7'b0000000, 3'd5);
    row("cmp_wb", 1'b1, L_ALUWB,  7'b0000010, 3'd5);

    set_ins(2'b00, 6'b111010, 4'd15, 1'b1);  // MOV PC,#imm
    row("movpc_f",  1'b1, L_FETCH,  7'b1100000, 3'd6);
    row("movpc_d",  1'b1, L_DECODE, 7'b0000000, 3'd6);
    row("movpc_x",  1'b1, L_EXECI,  7'b0000000, 3'd6);
    row("movpc_wb", 1'b1, L_ALUWB,  7'b1001010, 3'd6);

    set_ins(2'b11, 6'b000000, 4'd0, 1'b1);  // undefined opcode
    row("ill_f", 1'b1, L_FETCH,  7'b1100000, 3'd7);
    row("ill_d", 1'b1, L_DECODE, 7'b0000001, 3'd7);

    set_ins(2'b00, 6'b101000, 4'd4, 1'b1);  // ADD imm, counter wraps after it
    row("addi_f",  1'b1, L_FETCH,  7'b1100000, 3'd7);
    row("addi_d",  1'b1, L_DECODE, 7'b0000000, 3'd7);
    row("addi_x",  1'b1, L_EXECI,  7'b0000000, 3'd7);
    row("addi_wb", 1'b1, L_ALUWB,  7'b0001010, 3'd7);

    set_ins(2'b10, 6'b100000, 4'd0, 1'b1);
    row("wrap_f",  1'b1, L_FETCH,  7'b1100000, 3'd0);
    row("wrap_d",  1'b1, L_DECODE, 7'b0000000, 3'd0);
    row("wrap_br", 1'b1, L_BRANCH, 7'b1000110, 3'd0);

    set_ins(2'b01, 6'b011000, 4'd5, 1'b1);  // STR aborted by reset
    row("str_f",  1'b1, L_FETCH,  7'b1100000, 3'd1);
    row("str_d",  1'b1, L_DECODE, 7'b0000000, 3'd1);
    row("str_ma", 1'b1, L_MEMADR, 7'b0000000, 3'd1);
    row("str_w0", 1'b0, L_MEMWR,  7'b0010000, 3'd1);
    drive("abort0", 1'b0, 1'b1, L_FETCH, 7'b0000000, 3'd0);
    drive("abort1", 1'b0, 1'b1, L_FETCH, 7'b0000000, 3'd0);
    row("post_f", 1'b1, L_FETCH,  7'b1100000, 3'd0);
    row("post_d", 1'b0, L_DECODE, 7'b0000000, 3'd0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
